// File: rtl/boot_pkg.sv
// Shared state encoding and header constants for the BIOS boot sequencer.
package boot_pkg;

   typedef enum logic [1:0] {HDR, LEN, COPY, DONE} state_t;

   localparam int HDR_INDEX  = 0;
   localparam int ROM_AW_DEF = 9;
   localparam int MAX_LEN    = (1 << ROM_AW_DEF) - 1;

   function automatic int max_len(input int aw);
      return (1 << aw) - 1;
   endfunction

endpackage

// File: rtl/boot_skid.sv
// One-entry skid buffer between the ROM read stage and the main-memory write port.
module boot_skid #(
   parameter int DATA_WIDTH     = 16,
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_vld,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
   output logic                      in_rdy,
   output logic                      rdy_next,
   input  logic                      mem_ready,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata
);

   logic                      skid_vld;
   logic                      skid_vld_nxt;
   logic [DATA_WIDTH-1:0]     skid_data;
   logic [MEM_ADDR_WIDTH-1:0] skid_addr;
   logic                      in_fire;
   logic                      out_free;

   assign in_rdy       = !skid_vld;
   assign in_fire      = in_vld && !skid_vld;
   assign out_free     = !mem_we || mem_ready;
   assign skid_vld_nxt = skid_vld ? !out_free : (in_fire && !out_free);
   // Lets the reader hold the ROM address one cycle early, so the word it has
   // already launched always finds a slot.
   assign rdy_next     = !skid_vld_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_vld  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         skid_vld <= skid_vld_nxt;
         if (out_free) begin
            if (skid_vld) begin
               mem_we    <= 1'b1;
               mem_addr  <= skid_addr;
               mem_wdata <= skid_data;
            end else begin
               mem_we <= in_fire;
               if (in_fire) begin
                  mem_addr  <= in_addr;
                  mem_wdata <= in_data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire && !out_free) begin
         skid_data <= in_data;
         skid_addr <= in_addr;
      end
   end

endmodule

// File: rtl/bios_boot_loader.sv
// Boot sequencer: reads a length header from ROM word 0, copies words 1..L into
// main memory and holds the CPU halted until the last write is accepted.
module bios_boot_loader
   import boot_pkg::*;
#(
   parameter int                        DATA_WIDTH     = 16,
   parameter int                        ADDR_WIDTH     = 9,
   parameter int                        MEM_ADDR_WIDTH = 16,
   parameter logic [MEM_ADDR_WIDTH-1:0] DEST_BASE      = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      boot_req,
   output logic [ADDR_WIDTH-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0]     rom_q,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic                      mem_ready,
   output logic                      boot_done,
   output logic                      cpu_halt,
   output logic                      len_err
);

   localparam int LIMIT = max_len(ADDR_WIDTH);

   state_t                    state;
   logic [ADDR_WIDTH-1:0]     len;
   logic [ADDR_WIDTH-1:0]     rem;
   logic                      vld_p0;
   logic                      vld_p1;
   logic                      in_rdy;
   logic                      rdy_next;
   logic                      hdr_over;
   logic [ADDR_WIDTH-1:0]     hdr_len;
   logic                      issue;
   logic                      wr_fire;
   logic [MEM_ADDR_WIDTH-1:0] q_addr;

   assign hdr_over = 32'(rom_q) > 32'(LIMIT);
   assign hdr_len  = hdr_over ? ADDR_WIDTH'(LIMIT) : rom_q[ADDR_WIDTH-1:0];
   assign issue    = (state == COPY) && (rom_addr != len) && rdy_next;
   assign wr_fire  = mem_we && mem_ready;
   assign cpu_halt = !boot_done;

   // rom_q holds the word at the address presented one cycle earlier, which is
   // rom_addr minus one when the address advanced on the last edge.
   assign q_addr = DEST_BASE + MEM_ADDR_WIDTH'(rom_addr) - MEM_ADDR_WIDTH'(vld_p0)
                   - MEM_ADDR_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HDR;
         rom_addr  <= '0;
         len       <= '0;
         rem       <= '0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         boot_done <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         vld_p1 <= vld_p0 || (vld_p1 && !in_rdy);
         case (state)
            HDR: state <= LEN;
            LEN: begin
               len     <= hdr_len;
               rem     <= hdr_len;
               len_err <= hdr_over;
               if (hdr_len == '0) begin
                  state     <= DONE;
                  boot_done <= 1'b1;
               end else begin
                  rom_addr <= ADDR_WIDTH'(HDR_INDEX + 1);
                  vld_p0   <= 1'b1;
                  state    <= COPY;
               end
            end
            COPY: begin
               if (issue) begin
                  rom_addr <= rom_addr + ADDR_WIDTH'(1);
                  vld_p0   <= 1'b1;
               end
               if (wr_fire) begin
                  rem <= rem - ADDR_WIDTH'(1);
                  if (rem == ADDR_WIDTH'(1)) begin
                     state     <= DONE;
                     boot_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (boot_req) begin
                  state     <= HDR;
                  boot_done <= 1'b0;
                  len_err   <= 1'b0;
                  rom_addr  <= ADDR_WIDTH'(HDR_INDEX);
               end
            end
            default: state <= HDR;
         endcase
      end
   end

   // ROM read stage to write-port stage
   boot_skid #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (vld_p1),
      .in_data   (rom_q),
      .in_addr   (q_addr),
      .in_rdy    (in_rdy),
      .rdy_next  (rdy_next),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

endmodule

// File: doc/bios_boot_loader.md
# bios_boot_loader

Boot sequencer for the BIOS ROM. After reset it reads a length header from ROM word 0, then copies ROM words 1..L into main memory through a write port with ready backpressure. It holds the CPU halted until the copy completes. It sits between the BIOS ROM (synchronous read, one-cycle latency) and the main-memory write port, ahead of the CPU fetch path.

## Interface
- DATA_WIDTH, 16, ROM/memory word width
- ADDR_WIDTH, 9, ROM address width
- MEM_ADDR_WIDTH, 16, main-memory address width
- DEST_BASE, 0, main-memory address receiving ROM word 1

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- boot_req  in  1  restart pulse; honoured only in DONE
- rom_addr  out  ADDR_WIDTH  ROM read address (registered)
- rom_q  in  DATA_WIDTH  ROM data for the address presented the previous cycle
- mem_we  out  1  write valid
- mem_addr  out  MEM_ADDR_WIDTH  write address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- boot_done  out  1  copy complete
- cpu_halt  out  1  equals !boot_done
- len_err  out  1  header length exceeded capacity; sticky until reset or restart

## Operation
- Reset values: rom_addr=0, mem_we=0, mem_addr=0, mem_wdata=0, boot_done=0, cpu_halt=1, len_err=0; state HDR.
- HDR: ROM is reading word 0. Next state is LEN.
- LEN: latch L=rom_q.
  - If L > 2^ADDR_WIDTH−1 (511): set len_err and use L=511.
  - If L=0: go to DONE.
  - Otherwise: rom_addr←1 and go to COPY.
- COPY:
  - Stream ROM words 1..L. Word k is written to mem_addr = DEST_BASE + (k−1), modulo 2^MEM_ADDR_WIDTH.
  - Write fields stay stable while mem_we && !mem_ready.
  - A one-entry skid buffer absorbs the ROM word already in flight when a stall begins. rom_addr advances only when the in-flight word has a free slot, so no word is lost or duplicated.
  - After the L-th write is accepted, go to DONE and drop mem_we.
- DONE: boot_done=1. A boot_req pulse clears boot_done and len_err, sets rom_addr=0, and returns to HDR. boot_req in any other state is ignored.
- rst_n asserted mid-copy: all outputs return to reset values immediately (asynchronously); the copy restarts from HDR after release.
- ROM words beyond index L are never read.

## Timing
- Edges are counted from rst_n deassertion (edge 1 is the first rising edge with rst_n=1).
- Edge 1: ROM captures word 0; state moves to LEN.
- Edge 2: L is latched; rom_addr=1.
- Edge 3: rom_q=word 1.
- Edge 4: mem_we=1, mem_wdata=word 1, mem_addr=DEST_BASE.
- With mem_ready held 1, throughput is one write per cycle. Writes are accepted on edges 5..4+L, and boot_done rises after edge 4+L.
- L=0: boot_done rises after edge 2; mem_we never asserts.
- Each cycle of mem_ready=0 while mem_we=1 delays boot_done by exactly one cycle.
- boot_req sampled on edge n in DONE: boot_done=0 after edge n; the sequence then repeats with edge n+1 taking the role of edge 1.

## Structure
- Package boot_pkg holds:
  - the state enum {HDR, LEN, COPY, DONE}
  - HDR_INDEX=0
  - MAX_LEN = 2^ADDR_WIDTH−1
- Sub-module boot_skid: a one-entry valid/ready skid buffer (data plus address) between the ROM read stage and the mem_* outputs. The top level contains only the FSM, the read pointer, and the remaining-word counter.

## Test plan
- Word 0=3, words 1..3=A1,A2,A3, DEST_BASE=0x100, mem_ready=1 -> writes 0x100=A1, 0x101=A2, 0x102=A3 on edges 5,6,7; boot_done high after edge 7; cpu_halt low from then on.
- Word 0=0 -> no mem_we ever; boot_done high after edge 2.
- L=4 with mem_ready=0 for 3 cycles while the 2nd write is pending -> mem_addr/mem_wdata held stable through the stall; all 4 words written in order, no duplicates; boot_done 3 cycles later than the unstalled case.
- Word 0=0xFFFF -> len_err=1; exactly 511 writes, the last to DEST_BASE+510; boot_done=1.
- rst_n pulsed low after the 2nd accepted write -> mem_we=0 and cpu_halt=1 immediately; after release the full sequence restarts from word 1.
- boot_req pulsed in DONE -> boot_done drops after that edge and the copy repeats with identical writes; boot_req pulsed during COPY is ignored.
